// File: rtl/axis_fifo_arbiter.sv
// Packet-level round-robin arbiter sharing one tready-less AXIS FIFO write port
// among N_REQ requesters, with flow control from the FIFO's level/full feedback.
module axis_fifo_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int USER_WIDTH  = 1,
   parameter int FIFO_LEN    = 8,
   parameter int HEADROOM    = 2,
   parameter int MAX_PKT_LEN = 64
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]    s_axis_in_tdata,
   input  logic [N_REQ*USER_WIDTH-1:0]    s_axis_in_tuser,
   input  logic [N_REQ-1:0]               s_axis_in_tlast,
   input  logic [N_REQ-1:0]               s_axis_in_tvalid,
   output logic [N_REQ-1:0]               s_axis_in_tready,
   output logic [DATA_WIDTH-1:0]          m_axis_out_tdata,
   output logic [USER_WIDTH-1:0]          m_axis_out_tuser,
   output logic                           m_axis_out_tlast,
   output logic                           m_axis_out_tvalid,
   input  logic [$clog2(FIFO_LEN)-1:0]    fifo_level_i,
   input  logic                           fifo_full_i,
   output logic [$clog2(N_REQ)-1:0]       grant_id_o,
   output logic                           busy_o,
   output logic                           truncated_o
);

   localparam int GW = $clog2(N_REQ);
   localparam int LW = $clog2(FIFO_LEN);
   localparam int CW = $clog2(MAX_PKT_LEN + 1);
   localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_LEN - 1 - HEADROOM);
   localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_PKT_LEN - 1);

   typedef enum logic {IDLE, PKT} state_t;

   state_t                  state;
   logic [GW-1:0]           rr;
   logic [GW-1:0]           winner;
   logic [GW-1:0]           scan_idx;
   logic                    any_valid;
   logic [CW-1:0]           word_cnt;
   logic                    space_ok;
   logic                    xfer;
   logic                    force_last;
   logic                    out_last;
   logic [DATA_WIDTH-1:0]   in_data [N_REQ];
   logic [USER_WIDTH-1:0]   in_user [N_REQ];

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         in_data[k] = s_axis_in_tdata[k*DATA_WIDTH +: DATA_WIDTH];
         in_user[k] = s_axis_in_tuser[k*USER_WIDTH +: USER_WIDTH];
      end
   end

   // Level wraps to 0 when the FIFO is full, so full must override the level test.
   always_comb begin
      space_ok = !fifo_full_i && (fifo_level_i <= LEVEL_MAX);
   end

   // Scan from rr+N down to rr+1 so the nearest valid requester after rr wins last.
   always_comb begin
      winner    = rr;
      any_valid = 1'b0;
      scan_idx  = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         scan_idx = GW'((int'(rr) + i) % N_REQ);
         if (s_axis_in_tvalid[scan_idx]) begin
            winner    = scan_idx;
            any_valid = 1'b1;
         end
      end
   end

   always_comb begin
      s_axis_in_tready = '0;
      if (state == PKT) begin
         s_axis_in_tready[grant_id_o] = space_ok;
      end
      xfer       = s_axis_in_tvalid[grant_id_o] & s_axis_in_tready[grant_id_o];
      force_last = (word_cnt == CNT_LAST);
      out_last   = s_axis_in_tlast[grant_id_o] | force_last;
   end

   assign busy_o = (state == PKT);

   // Output register stage: one cycle of latency from accepted input word to FIFO write.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state             <= IDLE;
         rr                <= GW'(N_REQ - 1);
         grant_id_o        <= '0;
         word_cnt          <= '0;
         m_axis_out_tdata  <= '0;
         m_axis_out_tuser  <= '0;
         m_axis_out_tlast  <= 1'b0;
         m_axis_out_tvalid <= 1'b0;
         truncated_o       <= 1'b0;
      end else begin
         m_axis_out_tvalid <= 1'b0;
         truncated_o       <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id_o <= winner;
                  rr         <= winner;
                  word_cnt   <= '0;
                  state      <= PKT;
               end
            end
            PKT: begin
               if (xfer) begin
                  m_axis_out_tdata  <= in_data[grant_id_o];
                  m_axis_out_tuser  <= in_user[grant_id_o];
                  m_axis_out_tlast  <= out_last;
                  m_axis_out_tvalid <= 1'b1;
                  truncated_o       <= force_last & ~s_axis_in_tlast[grant_id_o];
                  word_cnt          <= word_cnt + 1'b1;
                  if (out_last) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
